uart_rx_frame: RTL and testbench

//  8N1 UART receiver; the receive end of the serial link driven by the board's
//  o_Tx_Serial transmitter. Synchronises i_Rx_Serial, detects start, samples each
//  bit at its centre and presents the byte with a one-cycle valid strobe.

---
 rtl/uart_rx_frame_if.sv | 28 ++
 rtl/uart_rx_frame.sv | 136 +++++++++++++
 tb/tb_uart_rx_frame.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// Serial-receive bundle: the line into the receiver and everything it reports back.
`timescale 1ns/1ps
interface uart_rx_frame_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Frame_Err;
    logic       o_Busy;
    logic [7:0] o_Rx_Count;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Frame_Err,
        input  o_Busy,
        input  o_Rx_Count
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Frame_Err,
        output o_Busy,
        output o_Rx_Count
    );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises the line, samples each bit at its centre,
// strobes good bytes or framing errors and counts good bytes.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input logic            clock,
    input logic            reset,
    uart_rx_frame_if.slave rx_if
);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic                   rx_dv;
    logic [7:0]             rx_byte;
    logic                   frame_err;
    logic                   busy;
    logic [7:0]             rx_count;

    assign rx_s = sync_q[SYNC_STAGES-1];

    assign rx_if.o_Rx_DV     = rx_dv;
    assign rx_if.o_Rx_Byte   = rx_byte;
    assign rx_if.o_Frame_Err = frame_err;
    assign rx_if.o_Busy      = busy;
    assign rx_if.o_Rx_Count  = rx_count;

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '1;
            state     <= S_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            rx_dv     <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            rx_count  <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_if.i_Rx_Serial};
            rx_dv     <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                // A start bit that is high again at its centre was only a glitch.
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt          <= '0;
                        shift_q[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            rx_byte  <= shift_q;
                            rx_dv    <= 1'b1;
                            rx_count <= rx_count + 8'd1;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end

                // A line held low reports one error, then waits here for idle.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and random frames against a byte-level model of what the receiver must report.
`timescale 1ns/1ps
module tb_uart_rx_frame;
    localparam int CPB  = 8;
    localparam int SYNC = 2;
    localparam int HALF = (CPB - 1) / 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_rx_frame_if rx_if ();

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_if(rx_if)
    );

    always #5 clock = ~clock;

    int         assert_count = 0;
    int         fail_count   = 0;
    int         cycle        = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         exp_count    = 0;
    logic [7:0] exp_last     = 8'h00;
    int         exp_err      = 0;
    int         got_err      = 0;
    int         dv_stretch   = 0;
    int         err_stretch  = 0;
    int         both_high    = 0;
    logic       prev_dv      = 1'b0;
    logic       prev_err     = 1'b0;
    int         checked      = 0;
    int         start_cyc    = 0;

    always @(posedge clock) cycle <= cycle + 1;

    // Record every strobe the receiver produces, plus any strobe wider than a cycle.
    always @(negedge clock) begin
        if (rx_if.o_Rx_DV === 1'b1) begin
            got_q.push_back(rx_if.o_Rx_Byte);
            got_cyc.push_back(cycle);
        end
        if (rx_if.o_Frame_Err === 1'b1) got_err++;
        if (rx_if.o_Rx_DV === 1'b1 && prev_dv) dv_stretch++;
        if (rx_if.o_Frame_Err === 1'b1 && prev_err) err_stretch++;
        if (rx_if.o_Rx_DV === 1'b1 && rx_if.o_Frame_Err === 1'b1) both_high++;
        prev_dv  <= (rx_if.o_Rx_DV === 1'b1);
        prev_err <= (rx_if.o_Frame_Err === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one 8N1 frame; optionally pulse reset in the middle of a data bit.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input int reset_bit);
        logic lvl;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = stop_bit;
            else             lvl = data[b-1];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                if (c == 0) begin
                    rx_if.i_Rx_Serial = lvl;
                    if (b == 0) start_cyc = cycle + 1;
                end
                if (reset_bit >= 0) reset = (b == reset_bit + 1) && (c == 4);
            end
        end
        if (reset_bit >= 0) begin
            exp_count = 0;
            exp_last  = 8'h00;
        end else if (stop_bit) begin
            exp_q.push_back(data);
            exp_count = (exp_count + 1) % 256;
            exp_last  = data;
        end else begin
            exp_err++;
            @(negedge clock);
            rx_if.i_Rx_Serial = 1'b1;
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (rx_if.o_Busy !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "_idle_timeout"}, 32'(n < 400), 32'd1);
    endtask

    task automatic check_model(input string tag);
        repeat (2) @(negedge clock);
        #1;
        checkOutput({tag, "_dv_pulses"}, got_q.size(), exp_q.size());
        for (int i = checked; i < exp_q.size(); i++) begin
            checkOutput({tag, "_byte"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'h100, 32'(exp_q[i]));
        end
        checked = exp_q.size();
        checkOutput({tag, "_rx_count"}, 32'(rx_if.o_Rx_Count), 32'(exp_count));
        checkOutput({tag, "_rx_byte"}, 32'(rx_if.o_Rx_Byte), 32'(exp_last));
        checkOutput({tag, "_frame_errs"}, got_err, exp_err);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset     = 1'b0;
        exp_count = 0;
        exp_last  = 8'h00;
    endtask

    initial begin
        int lat;
        int busy_cycles;
        logic [7:0] rb;
        bit         rs;

        rx_if.i_Rx_Serial = 1'b1;
        reset             = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_dv", 32'(rx_if.o_Rx_DV), 32'd0);
        checkOutput("reset_err", 32'(rx_if.o_Frame_Err), 32'd0);
        checkOutput("reset_busy", 32'(rx_if.o_Busy), 32'd0);
        checkOutput("reset_byte", 32'(rx_if.o_Rx_Byte), 32'd0);
        checkOutput("reset_count", 32'(rx_if.o_Rx_Count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        $display("[TB] two good frames");
        applyStimulus(8'h55, 1'b1, -1);
        lat = start_cyc;
        applyStimulus(8'hA3, 1'b1, -1);
        wait_idle("t1");
        check_model("t1");
        lat = (got_cyc.size() > 0) ? got_cyc[0] - lat : -1;
        checkOutput("dv_latency_in_window",
                    32'(lat >= SYNC + HALF + 9 * CPB && lat <= SYNC + HALF + 9 * CPB + 2), 32'd1);

        $display("[TB] start glitch");
        @(negedge clock);
        rx_if.i_Rx_Serial = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rx_if.i_Rx_Serial = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rx_if.o_Busy === 1'b1) busy_cycles++;
        end
        checkOutput("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
        checkOutput("glitch_busy_bounded", 32'(busy_cycles <= HALF + SYNC), 32'd1);
        check_model("t2");

        $display("[TB] bad stop bit then recovery");
        applyStimulus(8'h3C, 1'b0, -1);
        wait_idle("t3a");
        applyStimulus(8'h81, 1'b1, -1);
        wait_idle("t3b");
        check_model("t3");

        $display("[TB] line held low");
        @(negedge clock);
        rx_if.i_Rx_Serial = 1'b0;
        repeat (40 * CPB) @(negedge clock);
        rx_if.i_Rx_Serial = 1'b1;
        exp_err++;
        wait_idle("t4a");
        checkOutput("break_busy_after_high", 32'(rx_if.o_Busy), 32'd0);
        repeat (CPB) @(negedge clock);
        applyStimulus(8'h5A, 1'b1, -1);
        wait_idle("t4b");
        check_model("t4");

        $display("[TB] 256 back-to-back frames");
        do_reset();
        repeat (4) @(negedge clock);
        for (int v = 0; v < 256; v++) applyStimulus(8'(v), 1'b1, -1);
        wait_idle("t5");
        check_model("t5");

        $display("[TB] reset mid-frame");
        applyStimulus(8'hF0, 1'b1, 4);
        #1;
        checkOutput("midreset_byte", 32'(rx_if.o_Rx_Byte), 32'd0);
        checkOutput("midreset_count", 32'(rx_if.o_Rx_Count), 32'd0);
        checkOutput("midreset_busy", 32'(rx_if.o_Busy), 32'd0);
        applyStimulus(8'h0F, 1'b1, -1);
        wait_idle("t6");
        check_model("t6");

        $display("[TB] random frames");
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            applyStimulus(rb, rs, -1);
            repeat ($urandom_range(0, 12)) @(negedge clock);
        end
        wait_idle("t7");
        check_model("t7");

        checkOutput("dv_single_cycle", dv_stretch, 0);
        checkOutput("err_single_cycle", err_stretch, 0);
        checkOutput("dv_err_exclusive", both_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
